// File: rtl/sccb_cfg_sequencer.sv
// Walks a {sub_addr, data} init table from a synchronous ROM and issues one SCCB write per entry,
// honouring END (16'hFFFF) and millisecond DELAY (sub_addr 8'hFE) pseudo-entries and retrying NACKs.
module sccb_cfg_sequencer #(
   parameter logic [7:0] DEV_ADDR  = 8'h60,
   parameter int          AW        = 8,
   parameter int          MS_TICKS  = 50000,
   parameter int          MAX_RETRY = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_start,
   output logic          cfg_busy,
   output logic          cfg_done,
   output logic          cfg_error,
   output logic [AW-1:0] err_index,
   output logic [AW-1:0] rom_addr,
   input  logic [15:0]   rom_data,
   output logic          sccb_start,
   output logic          sccb_rw,
   output logic [7:0]    sccb_addr,
   output logic [15:0]   sccb_data,
   input  logic          sccb_done,
   input  logic          sccb_ack_error,
   output logic [3:0]    dbg_state
);

   // Handshake: sccb_start is held high for the whole transaction and sccb_data is stable while
   // it is high; the controller ends it with a one-clk sccb_done, sccb_ack_error qualified by it.

   localparam int             TW        = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(MS_TICKS - 1);
   localparam logic [7:0]     MAX_R     = 8'(MAX_RETRY);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_GAP, S_DELAY, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t        state, next_state;
   logic [7:0]    retry;
   logic [7:0]    ms_cnt;
   logic [TW-1:0] tick;

   logic is_end, is_delay, delay_zero, last_addr, retry_ok, tick_wrap;

   assign is_end     = (rom_data == 16'hFFFF);
   assign is_delay   = (rom_data[15:8] == 8'hFE);
   assign delay_zero = (rom_data[7:0] == 8'h00);
   assign last_addr  = (rom_addr == {AW{1'b1}});
   assign retry_ok   = (retry < MAX_R);
   assign tick_wrap  = (tick == TICK_LAST);

   assign sccb_rw   = 1'b0;
   assign sccb_addr = DEV_ADDR;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      sccb_start = 1'b0;
      cfg_busy   = 1'b1;
      case (state)
         S_IDLE: begin
            cfg_busy = 1'b0;
            if (cfg_start) next_state = S_FETCH;
         end
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            if (is_end)        next_state = S_DONE;
            else if (is_delay) next_state = delay_zero ? S_NEXT : S_DELAY;
            else               next_state = S_WRITE;
         end
         S_WRITE: begin
            sccb_start = 1'b1;
            if (sccb_done) begin
               if (!sccb_ack_error) next_state = S_NEXT;
               else if (retry_ok)   next_state = S_GAP;
               else                 next_state = S_FAIL;
            end
         end
         S_GAP:   next_state = S_WRITE;
         S_DELAY: if (tick_wrap && ms_cnt == 8'd1) next_state = S_NEXT;
         S_NEXT:  next_state = last_addr ? S_DONE : S_FETCH;
         S_DONE: begin
            cfg_busy   = 1'b0;
            next_state = S_IDLE;
         end
         S_FAIL: begin
            cfg_busy   = 1'b0;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr  <= '0;
         sccb_data <= '0;
         retry     <= '0;
         ms_cnt    <= '0;
         tick      <= '0;
         cfg_done  <= 1'b0;
         cfg_error <= 1'b0;
         err_index <= '0;
      end else begin
         case (state)
            S_IDLE: if (cfg_start) begin
               rom_addr  <= '0;
               retry     <= '0;
               cfg_done  <= 1'b0;
               cfg_error <= 1'b0;
               err_index <= '0;
            end
            S_DECODE: begin
               if (is_delay) begin
                  ms_cnt <= rom_data[7:0];
                  tick   <= '0;
               end else if (!is_end) begin
                  sccb_data <= rom_data;
               end
            end
            S_WRITE: if (sccb_done && sccb_ack_error && retry_ok) retry <= retry + 8'd1;
            // One ms unit elapses per tick wrap, so DELAY lasts exactly data*MS_TICKS cycles.
            S_DELAY: begin
               if (tick_wrap) begin
                  tick   <= '0;
                  ms_cnt <= ms_cnt - 8'd1;
               end else begin
                  tick <= tick + TW'(1);
               end
            end
            S_NEXT: begin
               retry <= '0;
               if (!last_addr) rom_addr <= rom_addr + AW'(1);
            end
            default: ;
         endcase
         if (next_state == S_DONE) cfg_done <= 1'b1;
         if (next_state == S_FAIL) begin
            cfg_error <= 1'b1;
            err_index <= rom_addr;
         end
      end
   end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Randomized and directed bench for sccb_cfg_sequencer against a table-walk reference model,
// with a synchronous ROM model and an SCCB controller responder.
module tb_sccb_cfg_sequencer;

   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int MS    = 10;
   localparam int MR    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_start = 1'b0;
   logic          cfg_busy, cfg_done, cfg_error;
   logic [AW-1:0] err_index, rom_addr;
   logic [15:0]   rom_data;
   logic          sccb_start, sccb_rw;
   logic [7:0]    sccb_addr;
   logic [15:0]   sccb_data;
   logic          sccb_done = 1'b0;
   logic          sccb_ack_error = 1'b0;
   logic [3:0]    dbg_state;

   sccb_cfg_sequencer #(
      .DEV_ADDR(8'h60), .AW(AW), .MS_TICKS(MS), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index),
      .rom_addr(rom_addr), .rom_data(rom_data), .sccb_start(sccb_start),
      .sccb_rw(sccb_rw), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
      .sccb_done(sccb_done), .sccb_ack_error(sccb_ack_error), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // synchronous table ROM
   logic [15:0] rom[DEPTH];
   always @(posedge clk) rom_data <= rom[rom_addr];

   // SCCB controller responder: done after lat clk, NACKs entry i nack_left[i] times
   int            lat = 5;
   int            nack_n[DEPTH];
   int            nack_left[DEPTH];
   int            resp_cnt = 0;
   logic [AW-1:0] cur_idx = '0;
   bit            served = 1'b0;

   always @(negedge clk) begin
      sccb_done      = 1'b0;
      sccb_ack_error = 1'b0;
      if (!rst_n) begin
         resp_cnt = 0;
         served   = 1'b0;
      end else if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            sccb_done = 1'b1;
            if (nack_left[cur_idx] > 0) begin
               sccb_ack_error = 1'b1;
               nack_left[cur_idx]--;
            end
            served = 1'b1;
         end
      end else if (!sccb_start) begin
         served = 1'b0;
      end else if (!served) begin
         resp_cnt = lat;
         cur_idx  = rom_addr;
      end
   end

   // scoreboard: every sccb_start rise must match the next expected write
   logic [15:0] exp_q[$];
   bit          exp_retry_q[$];
   logic        prev_start = 1'b0;
   int          low_cnt = 100;
   logic [15:0] held = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_start = 1'b0;
         low_cnt    = 100;
      end else begin
         if (sccb_start && !prev_start) begin
            check_eq("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               logic [15:0] e;
               bit          r;
               e = exp_q.pop_front();
               r = exp_retry_q.pop_front();
               check_eq("wr_data", sccb_data, e);
               if (r) check_eq("retry_gap", low_cnt, 1);
            end
            check_eq("wr_addr", sccb_addr, 8'h60);
            check_eq("wr_rw", sccb_rw, 0);
            held = sccb_data;
         end else if (sccb_start) begin
            check_eq("data_stable", sccb_data, held);
         end
         low_cnt    = sccb_start ? 0 : low_cnt + 1;
         prev_start = sccb_start;
      end
   end

   // driver: model the walk from the table rules, run it, compare the outcome
   task automatic run_walk(input int pulse_at, input bit chk_lat, input bit chk_delay);
      bit exp_done = 0, exp_err = 0, finished = 0;
      int exp_idx = 0, exp_last = 0, exp_delay = 0, busy_cnt = 0, first = -1;
      for (int i = 0; i < DEPTH; i++) begin
         logic [15:0] e;
         e = rom[i];
         exp_last = i;
         if (e == 16'hFFFF) begin
            exp_done = 1;
            break;
         end
         if (e[15:8] == 8'hFE) begin
            exp_delay += int'(e[7:0]) * MS;
         end else begin
            int att;
            att = (nack_n[i] > MR) ? MR + 1 : nack_n[i] + 1;
            for (int a = 0; a < att; a++) begin
               exp_q.push_back(e);
               exp_retry_q.push_back(a > 0);
            end
            if (nack_n[i] > MR) begin
               exp_err = 1;
               exp_idx = i;
               break;
            end
         end
         if (i == DEPTH - 1) exp_done = 1;
      end
      for (int i = 0; i < DEPTH; i++) nack_left[i] = nack_n[i];

      @(negedge clk);
      cfg_start = 1'b1;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge clk);
         cfg_start = (cyc == pulse_at);
         if (cyc == 1) begin
            check_eq("clr_done", cfg_done, 0);
            check_eq("clr_err", cfg_error, 0);
            check_eq("busy_on", cfg_busy, 1);
         end
         if (first < 0 && sccb_start) first = cyc;
         if (cfg_busy) busy_cnt++;
         else begin
            finished = 1;
            break;
         end
      end
      check_eq("finished", finished, 1);
      check_eq("cfg_done", cfg_done, exp_done);
      check_eq("cfg_error", cfg_error, exp_err);
      if (exp_err) check_eq("err_index", err_index, exp_idx);
      check_eq("last_addr", rom_addr, exp_last);
      check_eq("writes_left", exp_q.size(), 0);
      if (chk_lat) check_eq("start_latency", first, 3);
      if (chk_delay) check_eq("delay_cycles", busy_cnt - 5, exp_delay);
      exp_q.delete();
      exp_retry_q.delete();

      // a start during the DONE/FAIL cycle is not accepted
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check_eq("start_in_end_ignored", cfg_busy, 0);
      @(negedge clk);
      check_eq("done_latched", cfg_done, exp_done);
      check_eq("error_latched", cfg_error, exp_err);
   endtask

   task automatic set_table(input logic [15:0] t0, t1, t2, t3);
      rom[0] = t0; rom[1] = t1; rom[2] = t2; rom[3] = t3;
      for (int i = 0; i < DEPTH; i++) nack_n[i] = 0;
   endtask

   task automatic reset_mid_write();
      bit saw = 0;
      int starts = 0, busys = 0;
      set_table(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
      lat = 20;
      for (int i = 0; i < DEPTH; i++) nack_left[i] = 0;
      exp_q.push_back(16'h1280);
      exp_retry_q.push_back(1'b0);
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (sccb_start) begin
            saw = 1;
            break;
         end
      end
      check_eq("rst_saw_start", saw, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_sccb_start", sccb_start, 0);
      check_eq("rst_busy", cfg_busy, 0);
      check_eq("rst_rom_addr", rom_addr, 0);
      check_eq("rst_done", cfg_done, 0);
      exp_q.delete();
      exp_retry_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (sccb_start) starts++;
         if (cfg_busy) busys++;
      end
      check_eq("idle_after_rst_starts", starts, 0);
      check_eq("idle_after_rst_busy", busys, 0);
   endtask

   initial begin
      set_table(16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < DEPTH; i++) nack_left[i] = 0;
      repeat (3) @(negedge clk);
      check_eq("reset_busy", cfg_busy, 0);
      check_eq("reset_done", cfg_done, 0);
      check_eq("reset_error", cfg_error, 0);
      check_eq("reset_start", sccb_start, 0);
      check_eq("reset_rom_addr", rom_addr, 0);
      check_eq("reset_err_index", err_index, 0);
      check_eq("reset_sccb_addr", sccb_addr, 8'h60);
      check_eq("reset_sccb_data", sccb_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // two writes then END
      lat = 20;
      set_table(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
      run_walk(0, 1, 0);

      // delays of 3 ms and 0 ms
      set_table(16'hFE03, 16'hFFFF, 16'h0000, 16'h0000);
      run_walk(0, 0, 1);
      set_table(16'hFE00, 16'hFFFF, 16'h0000, 16'h0000);
      run_walk(0, 0, 1);

      // entry 2 NACKed twice then accepted
      lat = 6;
      set_table(16'h1280, 16'h1101, 16'h3344, 16'hFFFF);
      nack_n[2] = 2;
      run_walk(0, 0, 0);

      // entry 1 always NACKed, then a clean restart
      set_table(16'h1280, 16'h1101, 16'h3344, 16'hFFFF);
      nack_n[1] = 99;
      run_walk(0, 0, 0);
      set_table(16'h1280, 16'h1101, 16'h3344, 16'hFFFF);
      run_walk(0, 1, 0);

      // full table without END, with a start pulse mid-walk
      set_table(16'h1280, 16'h1101, 16'h3344, 16'h5566);
      run_walk(15, 0, 0);

      reset_mid_write();

      // randomized tables, NACK patterns and controller latency
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      rom[i] = 16'hFFFF;
            else if (r == 1) rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
            else             rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
            nack_n[i] = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4);
         end
         lat = $urandom_range(1, 8);
         run_walk(($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
